// File: rtl/mem_arbiter.sv
// Arbitrates the single line-wide memory port between I-cache fills and
// D-cache fills/writebacks, alternating grants on conflict.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              reqD_mem,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic              reqD_cache_write,
    input  logic [ADDR_W-1:0] reqAddrD_write_mem,
    input  logic [LINE_W-1:0] data_to_mem,
    output logic [LINE_W-1:0] data_from_mem,
    output logic              read_ready_from_mem,
    output logic              written_data_ack,
    output logic              readyI_from_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_WB   = 3'd1,
        ST_D_FILL = 3'd2,
        ST_I_FILL = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_cancel;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_fill_addr;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_data;
    logic              r_rd_ready;
    logic              r_wr_ack;
    logic              r_i_ready;

    state_t            w_state;
    logic              w_cancel;
    logic              w_last_d;
    logic [ADDR_W-1:0] w_fill_addr;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [LINE_W-1:0] w_mem_wdata;
    logic [LINE_W-1:0] w_data;
    logic              w_rd_ready;
    logic              w_wr_ack;
    logic              w_i_ready;
    logic              w_kill;
    logic              w_grant_d;

    // A flush seen in the completing cycle also cancels the transaction.
    assign w_kill    = r_cancel | flush;
    // D wins unless I is also pending and D had the previous grant.
    assign w_grant_d = reqD_mem & (~reqI_mem | ~r_last_d);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cancel    <= 1'b0;
            r_last_d    <= 1'b0;
            r_fill_addr <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_data      <= '0;
            r_rd_ready  <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_i_ready   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cancel    <= w_cancel;
            r_last_d    <= w_last_d;
            r_fill_addr <= w_fill_addr;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_data      <= w_data;
            r_rd_ready  <= w_rd_ready;
            r_wr_ack    <= w_wr_ack;
            r_i_ready   <= w_i_ready;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state     = r_state;
        w_cancel    = r_cancel;
        w_last_d    = r_last_d;
        w_fill_addr = r_fill_addr;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_data      = r_data;
        w_rd_ready  = 1'b0;
        w_wr_ack    = 1'b0;
        w_i_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_last_d    = 1'b1;
                    w_fill_addr = reqAddrD_mem;
                    w_mem_req   = 1'b1;
                    if (reqD_cache_write) begin
                        w_state     = ST_D_WB;
                        w_mem_we    = 1'b1;
                        w_mem_addr  = reqAddrD_write_mem;
                        w_mem_wdata = data_to_mem;
                    end else begin
                        w_state    = ST_D_FILL;
                        w_mem_addr = reqAddrD_mem;
                    end
                end else if (reqI_mem) begin
                    w_last_d   = 1'b0;
                    w_state    = ST_I_FILL;
                    w_mem_req  = 1'b1;
                    w_mem_addr = reqAddrI_mem;
                end
            end
            ST_D_WB: begin
                w_cancel = w_kill;
                if (!mem_ready) begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                end else if (w_kill) begin
                    w_state = ST_DONE;
                end else begin
                    w_wr_ack = 1'b1;
                    if (reqD_mem) begin
                        w_state    = ST_D_FILL;
                        w_mem_req  = 1'b1;
                        w_mem_addr = r_fill_addr;
                    end else begin
                        w_state = ST_DONE;
                    end
                end
            end
            ST_D_FILL, ST_I_FILL: begin
                w_cancel = w_kill;
                if (!mem_ready) begin
                    w_mem_req = 1'b1;
                end else begin
                    w_state = ST_DONE;
                    if (!w_kill) begin
                        w_data = mem_rdata;
                        if (r_state == ST_D_FILL) begin
                            w_rd_ready = 1'b1;
                        end else begin
                            w_i_ready = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_cancel = 1'b0;
                w_state  = ST_IDLE;
            end
            default: begin
                w_cancel = 1'b0;
                w_state  = ST_IDLE;
            end
        endcase
    end

    assign data_from_mem       = r_data;
    assign read_ready_from_mem = r_rd_ready;
    assign written_data_ack    = r_wr_ack;
    assign readyI_from_mem     = r_i_ready;
    assign mem_req             = r_mem_req;
    assign mem_we              = r_mem_we;
    assign mem_addr            = r_mem_addr;
    assign mem_wdata           = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// I/D agents checked against a transaction-level memory and fairness model.
module tb_mem_arbiter;

    logic         clk, reset, flush;
    logic         reqI_mem, reqD_mem, reqD_cache_write;
    logic [25:0]  reqAddrI_mem, reqAddrD_mem, reqAddrD_write_mem, mem_addr;
    logic [127:0] data_to_mem, data_from_mem, mem_wdata, mem_rdata;
    logic         read_ready_from_mem, written_data_ack, readyI_from_mem;
    logic         mem_req, mem_we, mem_ready;

    int n_cmp = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(26), .LINE_W(128)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .reqD_mem(reqD_mem), .reqAddrD_mem(reqAddrD_mem),
        .reqD_cache_write(reqD_cache_write), .reqAddrD_write_mem(reqAddrD_write_mem),
        .data_to_mem(data_to_mem), .data_from_mem(data_from_mem),
        .read_ready_from_mem(read_ready_from_mem), .written_data_ack(written_data_ack),
        .readyI_from_mem(readyI_from_mem), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [127:0] mem_arr [logic [25:0]];
    logic [127:0] ref_mem [logic [25:0]];
    int           mem_wait = 0;
    bit           rand_wait = 1'b0;
    int           cnt = 0;
    int           cur_wait = 0;
    logic [25:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    bit           pending = 1'b0;
    int           viol_drop = 0;

    function automatic logic [127:0] mem_default(input logic [25:0] a);
        mem_default = {4{32'(a) ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [25:0] a);
        ref_rd = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // Posedge snapshots: the request levels and reset the DUT actually sampled.
    logic snap_i = 1'b0, snap_d = 1'b0, snap_rst = 1'b0;
    always @(posedge clk) begin
        snap_i   <= reqI_mem;
        snap_d   <= reqD_mem;
        snap_rst <= reset;
    end

    always @(negedge clk) begin
        if (pending && !mem_req && snap_rst) viol_drop++;
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (mem_req) begin
            if (cnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
            if (cnt >= cur_wait) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    last_wr_addr      = mem_addr;
                    last_wr_data      = mem_wdata;
                end else begin
                    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_default(mem_addr);
                end
                cnt = 0;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
        pending = mem_req && !mem_ready;
    end

    // ---------------- protocol / fairness monitor ----------------
    bit mon_en = 1'b0;
    bit prev_req = 1'b0;
    bit ref_last_d = 1'b0;
    int viol_onehot = 0;
    int viol_fair = 0;
    int n_grants = 0;

    always @(negedge clk) begin
        bit side_d, exp_d;
        if ((32'(read_ready_from_mem) + 32'(written_data_ack) + 32'(readyI_from_mem)) > 32'd1)
            viol_onehot++;
        if (!snap_rst) ref_last_d = 1'b0;
        if (mon_en && mem_req && !prev_req) begin
            side_d = mem_we || !mem_addr[25];
            exp_d  = (snap_i && snap_d) ? !ref_last_d : snap_d;
            if (side_d != exp_d) viol_fair++;
            ref_last_d = side_d;
            n_grants++;
        end
        prev_req = mem_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [511:0] got;
        reset = 1'b0; reqI_mem = 1'b1; reqD_mem = 1'b1; reqD_cache_write = 1'b0;
        reqAddrI_mem = 26'h2000001; reqAddrD_mem = 26'h0000033; mem_wait = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = 512'({mem_req, mem_we, mem_addr, mem_wdata, data_from_mem,
                        read_ready_from_mem, written_data_ack, readyI_from_mem});
            n_cmp++;
            if (got !== '0) begin
                n_fail++; $display("FAIL reset_hold cyc%0d outputs=%h expected 0", c, got);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 26'h0000033}) begin
            n_fail++; $display("FAIL reset_first_grant req=%b we=%b addr=%h expected 1 0 033", mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({read_ready_from_mem, readyI_from_mem, data_from_mem} !== {2'b10, mem_default(26'h33)}) begin
            n_fail++; $display("FAIL reset_first_fill rr=%b ri=%b data=%h", read_ready_from_mem, readyI_from_mem, data_from_mem);
        end
        reqI_mem = 1'b0; reqD_mem = 1'b0;
        idle(2);
    endtask

    task automatic test_single_i();
        reqAddrI_mem = 26'h00000A5; reqI_mem = 1'b1; mem_wait = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, readyI_from_mem} !== {2'b10, 26'h00000A5, 1'b0}) begin
            n_fail++; $display("FAIL single_i_req req=%b we=%b addr=%h ri=%b", mem_req, mem_we, mem_addr, readyI_from_mem);
        end
        @(negedge clk);
        n_cmp++;
        if ({readyI_from_mem, mem_req, data_from_mem} !== {2'b10, {32{4'h1}}}) begin
            n_fail++; $display("FAIL single_i_pulse ri=%b req=%b data=%h", readyI_from_mem, mem_req, data_from_mem);
        end
        reqI_mem = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({readyI_from_mem, data_from_mem} !== {1'b0, {32{4'h1}}}) begin
            n_fail++; $display("FAIL single_i_width ri=%b data=%h expected 0 and held data", readyI_from_mem, data_from_mem);
        end
        idle(1);
    endtask

    task automatic test_dirty_d();
        logic [127:0] wd;
        logic [255:0] got, exp;
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        wd = {$urandom, $urandom, $urandom, $urandom};
        reqAddrD_write_mem = 26'h10; reqAddrD_mem = 26'h20; data_to_mem = wd;
        reqD_cache_write = 1'b1; reqD_mem = 1'b1;
        reqAddrI_mem = 26'h2000005; reqI_mem = 1'b1; mem_wait = 2;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            got = '0; exp = '0;
            if (j <= 3) begin
                got = 256'({mem_req, mem_we, mem_addr, mem_wdata, written_data_ack, readyI_from_mem});
                exp = 256'({2'b11, 26'h10, wd, 2'b00});
            end else if (j <= 6) begin
                got = 256'({mem_req, mem_we, mem_addr, written_data_ack, read_ready_from_mem, readyI_from_mem});
                exp = 256'({2'b10, 26'h20, (j == 4), 2'b00});
            end else if (j == 7) begin
                got = 256'({mem_req, read_ready_from_mem, written_data_ack, readyI_from_mem, last_wr_addr, last_wr_data});
                exp = 256'({4'b0100, 26'h10, wd});
                reqD_mem = 1'b0; reqD_cache_write = 1'b0; mem_wait = 0;
            end else if (j == 8) begin
                got = 256'({mem_req, readyI_from_mem, data_from_mem});
                exp = 256'({2'b00, mem_default(26'h20)});
            end else if (j == 9) begin
                got = 256'({mem_req, mem_we, mem_addr});
                exp = 256'({2'b10, 26'h2000005});
            end else begin
                got = 256'({readyI_from_mem, data_from_mem});
                exp = 256'({1'b1, mem_default(26'h2000005)});
                reqI_mem = 1'b0;
            end
            n_cmp++;
            if (got !== exp) begin
                n_fail++; $display("FAIL dirty_d cyc%0d got=%h exp=%h", j, got, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_fairness();
        logic [25:0] addrs [4];
        int cycs [4];
        int ng = 0;
        bit prv = 1'b0;
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        reqAddrD_mem = 26'h0000044; reqAddrI_mem = 26'h2000044; reqD_cache_write = 1'b0;
        reqD_mem = 1'b1; reqI_mem = 1'b1; mem_wait = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (mem_req && !prv) begin addrs[ng] = mem_addr; cycs[ng] = c; ng++; end
            prv = mem_req;
        end
        reqD_mem = 1'b0; reqI_mem = 1'b0;
        n_cmp++;
        if (ng != 4) begin
            n_fail++; $display("FAIL fair_count grants=%0d expected 4", ng);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (addrs[k] !== ((k % 2 == 0) ? 26'h0000044 : 26'h2000044)) begin
                    n_fail++; $display("FAIL fair_order grant%0d addr=%h", k, addrs[k]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                n_cmp++;
                if (cycs[k] - cycs[k-1] != 3) begin
                    n_fail++; $display("FAIL fair_spacing grant%0d spacing=%0d expected 3", k, cycs[k] - cycs[k-1]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_flush();
        logic [7:0] got, exp;
        reqAddrI_mem = 26'h2000077; reqI_mem = 1'b1; mem_wait = 3;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            flush = (j == 1);
            if (j == 4) mem_wait = 0;
            got = {4'b0, mem_req, readyI_from_mem, read_ready_from_mem, written_data_ack};
            exp = (j <= 4 || j == 7) ? 8'b0000_1000 : (j == 8) ? 8'b0000_0100 : 8'b0;
            n_cmp++;
            if (got !== exp) begin
                n_fail++; $display("FAIL flush cyc%0d req/ri/rr/ack=%b expected %b", j, got[3:0], exp[3:0]);
            end
            if (j == 8) begin
                n_cmp++;
                if (data_from_mem !== mem_default(26'h2000077)) begin
                    n_fail++; $display("FAIL flush_refill data=%h", data_from_mem);
                end
                reqI_mem = 1'b0;
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid_wb();
        logic [255:0] got;
        reqAddrD_write_mem = 26'h11; reqAddrD_mem = 26'h21; data_to_mem = {4{32'hDEADBEEF}};
        reqD_cache_write = 1'b1; reqD_mem = 1'b1; mem_wait = 5;
        idle(2);
        n_cmp++;
        if ({mem_req, mem_we} !== 2'b11) begin
            n_fail++; $display("FAIL rst_wb_active req=%b we=%b expected 1 1", mem_req, mem_we);
        end
        reset = 1'b0;
        @(negedge clk);
        got = 256'({mem_req, mem_we, mem_addr, mem_wdata, written_data_ack, read_ready_from_mem, readyI_from_mem});
        n_cmp++;
        if (got !== '0) begin
            n_fail++; $display("FAIL rst_wb_abandon outputs=%h expected 0", got);
        end
        reset = 1'b1; reqD_mem = 1'b0; reqD_cache_write = 1'b0; mem_wait = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, written_data_ack} !== 2'b00) begin
            n_fail++; $display("FAIL rst_wb_noack req=%b ack=%b expected 0 0", mem_req, written_data_ack);
        end
        reqAddrI_mem = 26'h2000099; reqI_mem = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 26'h2000099}) begin
            n_fail++; $display("FAIL rst_wb_idle req=%b we=%b addr=%h", mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        reqI_mem = 1'b0;
        n_cmp++;
        if (viol_drop != 0) begin
            n_fail++; $display("FAIL mem_req_dropped count=%0d expected 0", viol_drop);
        end
        idle(2);
    endtask

    task automatic agent_i(input int ntx);
        logic [25:0] a;
        int t;
        for (int k = 0; k < ntx; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = {2'b10, 24'($urandom_range(0, 15))};
            reqAddrI_mem = a; reqI_mem = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!readyI_from_mem && t < 100);
            n_cmp++;
            if (!readyI_from_mem) begin
                n_fail++; $display("FAIL rand_i_timeout txn%0d ready=0 expected 1", k);
            end else begin
                n_cmp++;
                if (data_from_mem !== ref_rd(a)) begin
                    n_fail++; $display("FAIL rand_i_data txn%0d got=%h exp=%h", k, data_from_mem, ref_rd(a));
                end
            end
            reqI_mem = 1'b0;
        end
    endtask

    task automatic agent_d(input int ntx);
        logic [25:0]  fa, wa;
        logic [127:0] wd;
        bit           dirty, seen;
        int           t;
        for (int k = 0; k < ntx; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fa = {2'b01, 24'($urandom_range(0, 7))};
            wa = {2'b01, 24'($urandom_range(0, 7))};
            wd = {$urandom, $urandom, $urandom, $urandom};
            dirty = 1'($urandom_range(0, 1));
            reqAddrD_mem = fa; reqAddrD_write_mem = wa; data_to_mem = wd;
            reqD_cache_write = dirty; reqD_mem = 1'b1;
            if (dirty) begin
                seen = 1'b0; t = 0;
                while (!seen && t < 100) begin
                    @(negedge clk); t++;
                    seen = written_data_ack;
                end
                n_cmp++;
                if (!seen) begin
                    n_fail++; $display("FAIL rand_d_ack_timeout txn%0d ack=0 expected 1", k);
                end else begin
                    n_cmp++;
                    if ({last_wr_addr, last_wr_data} !== {wa, wd}) begin
                        n_fail++; $display("FAIL rand_d_wb txn%0d addr=%h data=%h exp %h %h", k, last_wr_addr, last_wr_data, wa, wd);
                    end
                    ref_mem[wa] = wd;
                end
            end
            t = 0;
            do begin @(negedge clk); t++; end while (!read_ready_from_mem && t < 100);
            n_cmp++;
            if (!read_ready_from_mem) begin
                n_fail++; $display("FAIL rand_d_timeout txn%0d ready=0 expected 1", k);
            end else begin
                n_cmp++;
                if (data_from_mem !== ref_rd(fa)) begin
                    n_fail++; $display("FAIL rand_d_data txn%0d got=%h exp=%h", k, data_from_mem, ref_rd(fa));
                end
            end
            reqD_mem = 1'b0; reqD_cache_write = 1'b0;
        end
    endtask

    task automatic test_random();
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        n_grants = 0; viol_fair = 0; rand_wait = 1'b1; mon_en = 1'b1;
        fork
            agent_i(20);
            agent_d(20);
        join
        idle(3);
        mon_en = 1'b0; rand_wait = 1'b0;
        n_cmp++;
        if (viol_fair != 0) begin
            n_fail++; $display("FAIL rand_fairness violations=%0d expected 0", viol_fair);
        end
        n_cmp++;
        if (n_grants != 40) begin
            n_fail++; $display("FAIL rand_grant_count grants=%0d expected 40", n_grants);
        end
        n_cmp++;
        if (viol_onehot != 0) begin
            n_fail++; $display("FAIL ready_onehot violations=%0d expected 0", viol_onehot);
        end
        n_cmp++;
        if (viol_drop != 0) begin
            n_fail++; $display("FAIL rand_req_dropped count=%0d expected 0", viol_drop);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_cache_write = 1'b0;
        reqAddrI_mem = '0; reqAddrD_mem = '0; reqAddrD_write_mem = '0; data_to_mem = '0;
        mem_arr[26'h00000A5] = {32{4'h1}};
        ref_mem[26'h00000A5] = {32{4'h1}};
        test_reset();
        test_single_i();
        test_dirty_d();
        test_fairness();
        test_flush();
        test_reset_mid_wb();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
